pipo_reg: RTL and testbench

PIPO_REG -- requirements
Module: pipo_reg

---
 rtl/pipo_reg.sv | 47 ++++
 tb/tb_pipo_reg.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pipo_reg.sv
// pipo_reg: parallel-in / parallel-out register.
// Every bit of d is captured into q on each rising clk edge. The synchronous,
// active-high clr loads RESET_VALUE instead. There is no enable: the register
// reloads on every edge. Each bit lives in its own pipo_bit cell, which keeps
// the bit-for-bit mapping of d to q explicit.

module pipo_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  // One storage bit. clr wins over d at the same edge.
  always_ff @(posedge clk) begin
    if (clr) q <= RST_BIT;
    else     q <= d;
  end

endmodule

module pipo_reg #(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // One cell per bit index. q[i] sees only d[i] and its own reset bit, so
  // bits cannot be reordered, inverted or shifted.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pipo_bit #(
      .RST_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk (clk),
      .clr (clr),
      .d   (d[i]),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_pipo_reg.sv
// Directed bench for pipo_reg. Two instances are driven side by side:
// - the default configuration (4 bits, reset value 0);
// - an 8-bit configuration with a non-zero reset value. Its d is {~d, d}.
// Expected values are queued when the stimulus is driven and popped when q is sampled.
`timescale 1ns/1ps

module tb_pipo_reg;

  localparam logic [7:0] RV2 = 8'hA5;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [3:0] d   = 4'h0;
  logic [7:0] d2;
  logic [3:0] q;
  logic [7:0] q2;

  int checks = 0;
  int errors = 0;

  logic [3:0] sb  [$];
  logic [7:0] sb2 [$];

  assign d2 = {~d, d};

  always #1 clk = ~clk;

  pipo_reg u_dut (
    .clk (clk),
    .clr (clr),
    .d   (d),
    .q   (q)
  );

  pipo_reg #(.WIDTH(8), .RESET_VALUE(RV2)) u_dut2 (
    .clk (clk),
    .clr (clr),
    .d   (d2),
    .q   (q2)
  );

  // Queue the values both registers should show at the next sample point.
  task automatic push_exp(input logic [3:0] dv, input logic cv);
    sb.push_back(cv ? 4'h0 : dv);
    sb2.push_back(cv ? RV2 : {~dv, dv});
  endtask

  // Pop the oldest expectations and compare them against both outputs.
  task automatic chk(input string tag);
    logic [3:0] e;
    logic [7:0] e2;
    checks += 2;
    if (sb.size() == 0 || sb2.size() == 0) begin
      errors += 2;
      $error("FAIL %s: scoreboard empty, q=%h q2=%h", tag, q, q2);
    end else begin
      e  = sb.pop_front();
      e2 = sb2.pop_front();
      assert (q === e) else begin
        errors++;
        $error("FAIL %s: q=%h expected %h", tag, q, e);
      end
      assert (q2 === e2) else begin
        errors++;
        $error("FAIL %s (w8): q2=%h expected %h", tag, q2, e2);
      end
    end
  endtask

  // Drive on the falling edge, then sample half a nanosecond after the rising edge.
  task automatic step(input logic [3:0] dv, input logic cv, input string tag);
    @(negedge clk);
    d   = dv;
    clr = cv;
    push_exp(dv, cv);
    @(posedge clk);
    #0.5;
    chk(tag);
  endtask

  initial begin
    // Hold reset for 10 ns with d=0. q must be the reset value after each edge.
    for (int i = 0; i < 5; i++) step(4'h0, 1'b1, "reset_hold");

    // Release reset. Toggle bit 0, one value per clock period.
    step(4'h1, 1'b0, "stream_1");
    step(4'h0, 1'b0, "stream_0");
    step(4'h1, 1'b0, "stream_1b");
    step(4'h0, 1'b0, "stream_0b");

    // clr and d=1111 at the same edge: clr has priority.
    // On the next edge, the first after release, 1111 loads with no recovery cycle.
    step(4'hF, 1'b1, "clr_priority");
    step(4'hF, 1'b0, "clr_release");

    // Load 1010. A short glitch to 0101 that misses the edge must not reach q.
    step(4'hA, 1'b0, "load_1010");
    #0.2 d = 4'h5;
    #0.2 d = 4'hA;
    push_exp(4'hA, 1'b0);
    chk("glitch_hold");

    // Walk a single 1 through every bit position, then all ones and all zeros.
    step(4'h1, 1'b0, "walk_0001");
    step(4'h2, 1'b0, "walk_0010");
    step(4'h4, 1'b0, "walk_0100");
    step(4'h8, 1'b0, "walk_1000");
    step(4'hF, 1'b0, "walk_1111");
    step(4'h0, 1'b0, "walk_0000");

    // Assert clr mid-cycle with d=1100.
    // q holds its old value until the next edge, then takes the reset value.
    step(4'h3, 1'b0, "load_0011");
    d   = 4'hC;
    clr = 1'b1;
    #0.3;
    push_exp(4'h3, 1'b0);
    chk("clr_mid_hold");
    @(posedge clk);
    #0.5;
    push_exp(4'hC, 1'b1);
    chk("clr_mid_apply");

    // Reset in the middle of a stream: the in-flight value is discarded,
    // and the stream resumes on the next edge.
    step(4'h6, 1'b0, "recover_0110");
    step(4'h9, 1'b1, "stream_reset");
    step(4'h7, 1'b0, "resume_0111");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
